legv8_instr_encoder: RTL

Streaming LEGv8 instruction encoder, the inverse of the control decoder. Accepts one symbolic instruction per handshake (operation code, register fields, immediate). Emits the 32-bit machine word plus its target byte address for instruction-memory preload or a test-program loader. Range-checks immediates, and drops and counts instructions that cannot be encoded.

---
 rtl/legv8_instr_encoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/legv8_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : legv8_instr_encoder
//  Purpose  : Streaming LEGv8 instruction encoder. Takes one symbolic
//             instruction per handshake, range-checks the immediate and emits
//             the 32-bit machine word with its byte address. Instructions that
//             cannot be encoded are consumed, dropped and counted.
//  Revision : 1.0  initial release
// ============================================================================
module legv8_instr_encoder #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              rej,
  output logic [7:0]        err_count
);

  // Operation codes on in_op
  localparam logic [3:0] c_op_and  = 4'd0;
  localparam logic [3:0] c_op_orr  = 4'd1;
  localparam logic [3:0] c_op_add  = 4'd2;
  localparam logic [3:0] c_op_sub  = 4'd3;
  localparam logic [3:0] c_op_addi = 4'd4;
  localparam logic [3:0] c_op_subi = 4'd5;
  localparam logic [3:0] c_op_ldur = 4'd6;
  localparam logic [3:0] c_op_stur = 4'd7;
  localparam logic [3:0] c_op_cbz  = 4'd8;
  localparam logic [3:0] c_op_b    = 4'd9;
  localparam logic [3:0] c_op_movz = 4'd10;

  // Machine opcode fields
  localparam logic [10:0] c_opc_and  = 11'b10001010000;
  localparam logic [10:0] c_opc_orr  = 11'b10101010000;
  localparam logic [10:0] c_opc_add  = 11'b10001011000;
  localparam logic [10:0] c_opc_sub  = 11'b11001011000;
  localparam logic [9:0]  c_opc_addi = 10'b1001000100;
  localparam logic [9:0]  c_opc_subi = 10'b1101000100;
  localparam logic [10:0] c_opc_ldur = 11'b11111000010;
  localparam logic [10:0] c_opc_stur = 11'b11111000000;
  localparam logic [7:0]  c_opc_cbz  = 8'b10110100;
  localparam logic [5:0]  c_opc_b    = 6'b000101;
  localparam logic [8:0]  c_opc_movz = 9'b110100101;

  localparam logic [ADDR_W-1:0] c_addr_step = ADDR_W'(4);
  localparam logic [7:0]        c_err_max   = 8'hFF;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic              r_rej;
  logic [7:0]        r_err_count;

  logic [31:0]       w_enc;
  logic              w_legal;
  logic              w_accept;
  logic              w_out_fire;

  // Output stage can take a new word when empty or draining this cycle;
  // start blocks acceptance so nothing is half-taken while flushing.
  assign in_ready   = !Reset && !start && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_out_fire = r_out_valid && out_ready;

  // Combinational encode and immediate range check from the raw inputs
  always_comb begin
    w_enc   = '0;
    w_legal = 1'b0;
    case (in_op)
      c_op_and:  begin w_enc = {c_opc_and, in_rm, 6'b000000, in_rn, in_rd}; w_legal = 1'b1; end
      c_op_orr:  begin w_enc = {c_opc_orr, in_rm, 6'b000000, in_rn, in_rd}; w_legal = 1'b1; end
      c_op_add:  begin w_enc = {c_opc_add, in_rm, 6'b000000, in_rn, in_rd}; w_legal = 1'b1; end
      c_op_sub:  begin w_enc = {c_opc_sub, in_rm, 6'b000000, in_rn, in_rd}; w_legal = 1'b1; end
      c_op_addi: begin
        w_enc   = {c_opc_addi, in_imm[11:0], in_rn, in_rd};
        w_legal = (in_imm[31:12] == 20'd0);
      end
      c_op_subi: begin
        w_enc   = {c_opc_subi, in_imm[11:0], in_rn, in_rd};
        w_legal = (in_imm[31:12] == 20'd0);
      end
      // Signed 9-bit range: every bit above bit 8 must copy the sign bit
      c_op_ldur: begin
        w_enc   = {c_opc_ldur, in_imm[8:0], 2'b00, in_rn, in_rd};
        w_legal = (in_imm[31:8] == {24{in_imm[8]}});
      end
      c_op_stur: begin
        w_enc   = {c_opc_stur, in_imm[8:0], 2'b00, in_rn, in_rd};
        w_legal = (in_imm[31:8] == {24{in_imm[8]}});
      end
      c_op_cbz: begin
        w_enc   = {c_opc_cbz, in_imm[18:0], in_rd};
        w_legal = (in_imm[31:18] == {14{in_imm[18]}});
      end
      c_op_b: begin
        w_enc   = {c_opc_b, in_imm[25:0]};
        w_legal = (in_imm[31:25] == {7{in_imm[25]}});
      end
      // imm[17:16] is the shift selector hw, imm[15:0] the payload
      c_op_movz: begin
        w_enc   = {c_opc_movz, in_imm[17:16], in_imm[15:0], in_rd};
        w_legal = (in_imm[31:18] == 14'd0);
      end
      default: begin
        w_enc   = '0;
        w_legal = 1'b0;
      end
    endcase
  end

  // Output stage, address counter and reject bookkeeping
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= BASE_ADDR;
      r_rej       <= 1'b0;
      r_err_count <= '0;
    end else if (start) begin
      r_out_valid <= 1'b0;
      r_out_instr <= '0;
      r_out_addr  <= BASE_ADDR;
      r_rej       <= 1'b0;
      r_err_count <= '0;
    end else begin
      r_rej <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_err_count != c_err_max)) begin
        r_err_count <= r_err_count + 8'd1;
      end
      // Address advances when the current word leaves; a word loaded in
      // the same cycle therefore picks up the incremented address.
      if (w_out_fire) begin
        r_out_addr <= r_out_addr + c_addr_step;
      end
      if (w_accept && w_legal) begin
        r_out_valid <= 1'b1;
        r_out_instr <= w_enc;
      end else if (w_out_fire) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_instr = r_out_instr;
  assign out_addr  = r_out_addr;
  assign rej       = r_rej;
  assign err_count = r_err_count;

endmodule
`default_nettype wire
